// File: rtl/ca_row_serializer_if.sv
// Row bus and serial-link signals between the CA core, ca_row_serializer
// and the external 74HC595-style LED shift-register chain.
// master: CA core side. slave: serializer side.
interface ca_row_serializer_if #(
  parameter int N    = 7,
  parameter int ROWS = 8
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic          load;
  logic [N:0]    row;
  logic          ack;
  logic          busy;
  logic [AW-1:0] row_addr;
  logic          sclk;
  logic          sdata;
  logic          latch;

  modport master (
    output load, row,
    input  ack, busy, row_addr, sclk, sdata, latch
  );

  modport slave (
    input  load, row,
    output ack, busy, row_addr, sclk, sdata, latch
  );
endinterface

// File: rtl/ca_row_serializer.sv
// ca_row_serializer: captures an (N+1)-cell generation from the CA core and
// shifts it out on an sclk/sdata/latch link, then acks the core and advances
// the display row address. Every output is registered.
// Optional build macro: CA_SER_LSB_FIRST_EN -- shift row[0] first instead of row[N].
module ca_row_serializer #(
  parameter int N       = 7,
  parameter int CLK_DIV = 2,
  parameter int ROWS    = 8
) (
  input logic               clk,
  input logic               reset,
  ca_row_serializer_if.slave bus
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (N > 0) ? $clog2(N + 1) : 1;
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(N);
  localparam logic [AW-1:0] ADDR_LAST = AW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH,
    S_ACK,
    S_WAIT_LOW
  } state_t;

  state_t        r_state, w_state_nx;
  logic [N:0]    r_shreg, w_shreg_nx;
  logic [CW-1:0] r_bitcnt, w_bitcnt_nx;
  logic [7:0]    r_div, w_div_nx;
  logic          r_sclk, w_sclk_nx;
  logic          r_sdata, w_sdata_nx;
  logic          r_latch, w_latch_nx;
  logic          r_ack, w_ack_nx;
  logic          r_busy, w_busy_nx;
  logic [AW-1:0] r_row_addr, w_row_addr_nx;

  // Bit-order selection: first bit out of a fresh row, and the shifted
  // register whose leading bit is the next one to present.
  logic          w_first_bit;
  logic [N:0]    w_shifted;
  logic          w_next_bit;
`ifdef CA_SER_LSB_FIRST_EN
  assign w_first_bit = bus.row[0];
  assign w_shifted   = {1'b0, r_shreg[N:1]};
  assign w_next_bit  = w_shifted[0];
`else
  assign w_first_bit = bus.row[N];
  assign w_shifted   = {r_shreg[N-1:0], 1'b0};
  assign w_next_bit  = w_shifted[N];
`endif

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_bitcnt   <= '0;
      r_div      <= '0;
      r_sclk     <= 1'b0;
      r_sdata    <= 1'b0;
      r_latch    <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_row_addr <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_shreg    <= w_shreg_nx;
      r_bitcnt   <= w_bitcnt_nx;
      r_div      <= w_div_nx;
      r_sclk     <= w_sclk_nx;
      r_sdata    <= w_sdata_nx;
      r_latch    <= w_latch_nx;
      r_ack      <= w_ack_nx;
      r_busy     <= w_busy_nx;
      r_row_addr <= w_row_addr_nx;
    end
  end

  // Next-state and next-output logic; sclk phase is r_sclk itself and
  // r_div counts clk cycles within the current phase.
  always_comb begin
    w_state_nx    = r_state;
    w_shreg_nx    = r_shreg;
    w_bitcnt_nx   = r_bitcnt;
    w_div_nx      = r_div;
    w_sclk_nx     = r_sclk;
    w_sdata_nx    = r_sdata;
    w_latch_nx    = 1'b0;
    w_ack_nx      = 1'b0;
    w_row_addr_nx = r_row_addr;

    unique case (r_state)
      S_IDLE: begin
        w_sdata_nx = 1'b0;
        if (bus.load) begin
          w_shreg_nx  = bus.row;
          w_bitcnt_nx = '0;
          w_div_nx    = '0;
          w_sclk_nx   = 1'b0;
          w_sdata_nx  = w_first_bit;
          w_state_nx  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_div == DIV_LAST) begin
          w_div_nx = '0;
          if (!r_sclk) begin
            w_sclk_nx = 1'b1;
          end else begin
            w_sclk_nx = 1'b0;
            if (r_bitcnt == BIT_LAST) begin
              w_latch_nx = 1'b1;
              w_state_nx = S_LATCH;
            end else begin
              w_shreg_nx  = w_shifted;
              w_sdata_nx  = w_next_bit;
              w_bitcnt_nx = r_bitcnt + 1'b1;
            end
          end
        end else begin
          w_div_nx = r_div + 8'd1;
        end
      end
      S_LATCH: begin
        if (r_div == DIV_LAST) begin
          w_div_nx      = '0;
          w_ack_nx      = 1'b1;
          w_row_addr_nx = (r_row_addr == ADDR_LAST) ? '0 : r_row_addr + 1'b1;
          w_state_nx    = S_ACK;
        end else begin
          w_div_nx   = r_div + 8'd1;
          w_latch_nx = 1'b1;
        end
      end
      S_ACK: begin
        w_state_nx = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!bus.load) begin
          w_sdata_nx = 1'b0;
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    w_busy_nx = (w_state_nx != S_IDLE);
  end

  assign bus.ack      = r_ack;
  assign bus.busy     = r_busy;
  assign bus.row_addr = r_row_addr;
  assign bus.sclk     = r_sclk;
  assign bus.sdata    = r_sdata;
  assign bus.latch    = r_latch;
endmodule

// File: tb/tb_ca_row_serializer.sv
// Directed testbench for ca_row_serializer: a default instance
// (N=7, CLK_DIV=2, ROWS=8) and a CLK_DIV=1 instance for the fast variant.
module tb_ca_row_serializer;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  ca_row_serializer_if #(.N(7), .ROWS(8)) b1 ();
  ca_row_serializer_if #(.N(7), .ROWS(8)) b2 ();

  ca_row_serializer #(.N(7), .CLK_DIV(2), .ROWS(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  ca_row_serializer #(.N(7), .CLK_DIV(1), .ROWS(8)) u_dut_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7 - i];
    return r;
  endfunction

  // Row as it appears on the wire, first bit in position 7.
  function automatic logic [7:0] wire_order(input logic [7:0] v);
`ifdef CA_SER_LSB_FIRST_EN
    return rev8(v);
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    b1.load = 1'b0;
    b2.load = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    b1.load = 1'b1;
    b1.row  = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({b1.ack, b1.busy, b1.sclk, b1.sdata, b1.latch} !== 5'b0 || b1.row_addr !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: ack=%b busy=%b sclk=%b sdata=%b latch=%b row_addr=%0d, expected all 0",
                 i, b1.ack, b1.busy, b1.sclk, b1.sdata, b1.latch, b1.row_addr);
      end
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (b1.busy !== 1'b1 || b1.sdata !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_capture: busy=%b sdata=%b, expected busy=1 sdata=1", b1.busy, b1.sdata);
    end
    do_reset();
  endtask

  task automatic test_single_row();
    logic [7:0] row_v;
    logic [7:0] exp_w;
    logic [7:0] got;
    int         nbits;
    logic       prev;
    logic       e_sclk, e_latch, e_ack, e_busy;
    logic [2:0] e_addr;
    row_v   = 8'b1011_0010;
    exp_w   = wire_order(row_v);
    got     = '0;
    nbits   = 0;
    prev    = 1'b0;
    b1.row  = row_v;
    b1.load = 1'b1;
    for (int t = 0; t <= 36; t++) begin
      tick();
      if (b1.sclk === 1'b1 && prev === 1'b0) begin
        got = {got[6:0], b1.sdata};
        nbits++;
      end
      prev    = b1.sclk;
      e_sclk  = (t < 32) ? 1'((t >> 1) & 1) : 1'b0;
      e_latch = (t == 32 || t == 33);
      e_ack   = (t == 34);
      e_busy  = (t <= 35);
      e_addr  = (t >= 34) ? 3'd1 : 3'd0;
      n_tests++;
      if (b1.sclk !== e_sclk || b1.latch !== e_latch || b1.ack !== e_ack ||
          b1.busy !== e_busy || b1.row_addr !== e_addr) begin
        n_fail++;
        $display("FAIL single_row_ctrl t=%0d: sclk=%b latch=%b ack=%b busy=%b addr=%0d, expected %b %b %b %b %0d",
                 t, b1.sclk, b1.latch, b1.ack, b1.busy, b1.row_addr, e_sclk, e_latch, e_ack, e_busy, e_addr);
      end
      if (t < 32) begin
        n_tests++;
        if (b1.sdata !== exp_w[7 - t / 4]) begin
          n_fail++;
          $display("FAIL single_row_sdata t=%0d: sdata=%b, expected %b", t, b1.sdata, exp_w[7 - t / 4]);
        end
      end
      if (t == 34) b1.load = 1'b0;
    end
    n_tests++;
    if (got !== exp_w || nbits != 8) begin
      n_fail++;
      $display("FAIL single_row_bits: got=%b (%0d rises), expected %b (8 rises)", got, nbits, exp_w);
    end
  endtask

  task automatic test_slow_consumer();
    int   acks;
    logic seen;
    do_reset();
    acks    = 0;
    seen    = 1'b0;
    b1.row  = 8'h3C;
    b1.load = 1'b1;
    for (int t = 0; t < 60 && !seen; t++) begin
      tick();
      if (b1.ack === 1'b1) begin
        seen = 1'b1;
        acks++;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL slow_ack_timeout: ack=0 after 60 cycles, expected ack");
    end
    for (int t = 0; t < 5; t++) begin
      tick();
      if (b1.ack === 1'b1) acks++;
      n_tests++;
      if (b1.busy !== 1'b1 || b1.sclk !== 1'b0 || b1.latch !== 1'b0) begin
        n_fail++;
        $display("FAIL slow_hold t=%0d: busy=%b sclk=%b latch=%b, expected 1 0 0", t, b1.busy, b1.sclk, b1.latch);
      end
    end
    b1.load = 1'b0;
    tick();
    if (b1.ack === 1'b1) acks++;
    n_tests++;
    if (b1.busy !== 1'b0 || acks != 1 || b1.row_addr !== 3'd1) begin
      n_fail++;
      $display("FAIL slow_release: busy=%b acks=%0d row_addr=%0d, expected 0 1 1", b1.busy, acks, b1.row_addr);
    end
  endtask

  task automatic test_row_addr_wrap();
    logic       seen;
    logic [2:0] e_addr;
    do_reset();
    for (int r = 0; r < 9; r++) begin
      b1.row  = 8'(r * 37);
      b1.load = 1'b1;
      seen    = 1'b0;
      for (int t = 0; t < 60 && !seen; t++) begin
        tick();
        if (b1.ack === 1'b1) seen = 1'b1;
      end
      e_addr = 3'((r + 1) % 8);
      n_tests++;
      if (!seen || b1.row_addr !== e_addr) begin
        n_fail++;
        $display("FAIL wrap_row%0d: ack_seen=%b row_addr=%0d, expected ack_seen=1 row_addr=%0d", r, seen, b1.row_addr, e_addr);
      end
      b1.load = 1'b0;
      for (int t = 0; t < 5 && b1.busy !== 1'b0; t++) tick();
      n_tests++;
      if (b1.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_idle%0d: busy=%b, expected 0", r, b1.busy);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    logic       seen;
    logic       prev;
    logic [7:0] got;
    int         nbits;
    do_reset();
    b1.row  = 8'hFF;
    b1.load = 1'b1;
    seen    = 1'b0;
    for (int t = 0; t < 60 && !seen; t++) begin
      tick();
      if (b1.ack === 1'b1) seen = 1'b1;
    end
    b1.load = 1'b0;
    for (int t = 0; t < 5 && b1.busy !== 1'b0; t++) tick();
    n_tests++;
    if (!seen || b1.row_addr !== 3'd1) begin
      n_fail++;
      $display("FAIL midreset_prep: ack_seen=%b row_addr=%0d, expected 1 1", seen, b1.row_addr);
    end
    b1.load = 1'b1;
    for (int t = 0; t < 10; t++) tick();
    reset = 1'b1;
    tick();
    n_tests++;
    if ({b1.sclk, b1.latch, b1.ack, b1.busy, b1.sdata} !== 5'b0 || b1.row_addr !== 3'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: sclk=%b latch=%b ack=%b busy=%b sdata=%b row_addr=%0d, expected all 0",
               b1.sclk, b1.latch, b1.ack, b1.busy, b1.sdata, b1.row_addr);
    end
    reset   = 1'b0;
    b1.row  = 8'h5A;
    b1.load = 1'b1;
    seen    = 1'b0;
    prev    = 1'b0;
    got     = '0;
    nbits   = 0;
    for (int t = 0; t < 60 && !seen; t++) begin
      tick();
      if (b1.sclk === 1'b1 && prev === 1'b0) begin
        got = {got[6:0], b1.sdata};
        nbits++;
      end
      prev = b1.sclk;
      if (b1.ack === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen || got !== wire_order(8'h5A) || nbits != 8 || b1.row_addr !== 3'd1) begin
      n_fail++;
      $display("FAIL midreset_newrow: ack_seen=%b bits=%b (%0d) row_addr=%0d, expected 1 %b (8) 1",
               seen, got, nbits, b1.row_addr, wire_order(8'h5A));
    end
    b1.load = 1'b0;
    for (int t = 0; t < 5 && b1.busy !== 1'b0; t++) tick();
  endtask

  task automatic test_fast_variant();
    logic [7:0] exp_w;
    logic [7:0] got;
    int         nbits;
    logic       prev;
    logic       first_ok;
    do_reset();
    exp_w    = wire_order(8'h01);
    got      = '0;
    nbits    = 0;
    prev     = 1'b0;
    first_ok = 1'b0;
    b2.row   = 8'h01;
    b2.load  = 1'b1;
    tick();
    n_tests++;
    if (b2.busy !== 1'b1 || b2.sclk !== 1'b0 || b2.sdata !== exp_w[7]) begin
      n_fail++;
      $display("FAIL fast_capture: busy=%b sclk=%b sdata=%b, expected 1 0 %b", b2.busy, b2.sclk, b2.sdata, exp_w[7]);
    end
    for (int t = 1; t <= 17; t++) begin
      tick();
      if (b2.sclk === 1'b1 && prev === 1'b0) begin
        got = {got[6:0], b2.sdata};
        nbits++;
      end
      prev = b2.sclk;
      n_tests++;
      if (b2.ack !== (t == 17)) begin
        n_fail++;
        $display("FAIL fast_ack t=%0d: ack=%b, expected %b", t, b2.ack, (t == 17));
      end
    end
    n_tests++;
    if (got !== exp_w || nbits != 8) begin
      n_fail++;
      $display("FAIL fast_bits: got=%b (%0d rises), expected %b (8 rises)", got, nbits, exp_w);
    end
    b2.load = 1'b0;
    tick();
    tick();
    n_tests++;
    if (b2.busy !== 1'b0 || b2.row_addr !== 3'd1) begin
      n_fail++;
      $display("FAIL fast_idle: busy=%b row_addr=%0d, expected 0 1", b2.busy, b2.row_addr);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    b1.load = 1'b0;
    b1.row  = '0;
    b2.load = 1'b0;
    b2.row  = '0;
    tick();
    test_reset();
    test_single_row();
    test_slow_consumer();
    test_row_addr_wrap();
    test_reset_mid_shift();
    test_fast_variant();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
